// File: rtl/input_pattern_checker.sv
// rtl/input_pattern_checker.sv - memory-game player input checker: sync, debounce, compare presses to pattern
// Optional macro TIMEOUT_EN adds a WAIT_PRESS timeout that fails the session with fail_code 11.
module input_pattern_checker #(
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  level,
  input  logic [47:0] pattern_flat,
  input  logic [7:0]  btn,
  output logic [7:0]  led,
  output logic [4:0]  input_count,
  output logic        check_end,
  output logic        check_pass,
  output logic        check_fail,
  output logic [1:0]  fail_code
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] ARMED        = 3'd1;
  localparam logic [2:0] WAIT_PRESS   = 3'd2;
  localparam logic [2:0] WAIT_RELEASE = 3'd3;
  localparam logic [2:0] PASS         = 3'd4;
  localparam logic [2:0] FAIL         = 3'd5;

  localparam int         DBW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW:0] DB_TARGET = (DBW + 1)'(DEBOUNCE_CYCLES);

  logic [7:0]     sync1, sync2, last, db;
  logic [DBW-1:0] db_cnt;
  logic [DBW:0]   held;

  logic [2:0]  state;
  logic [47:0] pat;
  logic [4:0]  len, idx;
  logic [7:0]  pressed;
  logic [1:0]  code;

  logic [5:0] len_sum;
  logic [4:0] len_sat;
  logic [2:0] press_idx;
  logic [2:0] expected;
  logic       multi;
  logic       timeout_hit;

  // held = number of consecutive cycles sync2 has shown its current value, including this one
  always_comb begin
    held = {{DBW{1'b0}}, 1'b1};
    if (sync2 == last)
      held = {1'b0, db_cnt} + {{DBW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      sync1  <= 8'd0;
      sync2  <= 8'd0;
      last   <= 8'd0;
      db     <= 8'd0;
      db_cnt <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      last  <= sync2;
      if (held >= DB_TARGET) begin
        db     <= sync2;
        db_cnt <= DB_TARGET[DBW-1:0];
      end else begin
        db_cnt <= held[DBW-1:0];
      end
    end
  end

  always_comb begin
    len_sum = 6'd4 + {3'd0, level[0], 2'd0} + {2'd0, level[1], 3'd0} + (level[2] ? 6'd12 : 6'd0);
    len_sat = (len_sum > 6'd16) ? 5'd16 : len_sum[4:0];
  end

  always_comb begin
    press_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (db[i]) press_idx = 3'(i);
    multi    = (db & (db - 8'd1)) != 8'd0;
    expected = pat[3 * idx[3:0] +: 3];
  end

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst)
      tcnt <= '0;
    else if (state == WAIT_PRESS)
      tcnt <= tcnt + 1'b1;
    else
      tcnt <= '0;
  end

  // fires on the cycle whose increment brings the count to TIMEOUT_CYCLES
  assign timeout_hit = (state == WAIT_PRESS) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // never true for a legal TIMEOUT_CYCLES; keeps the parameter referenced in this build
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pat     <= 48'd0;
      len     <= 5'd0;
      idx     <= 5'd0;
      pressed <= 8'd0;
      code    <= 2'd0;
    end else if (!enable) begin
      state   <= IDLE;
      idx     <= 5'd0;
      pressed <= 8'd0;
      code    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          pat   <= pattern_flat;
          len   <= len_sat;
          idx   <= 5'd0;
          code  <= 2'd0;
          state <= ARMED;
        end
        ARMED: begin
          if (db == 8'd0) state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (db != 8'd0) begin
            if (multi) begin
              code  <= 2'b10;
              state <= FAIL;
            end else if (press_idx != expected) begin
              code  <= 2'b01;
              state <= FAIL;
            end else begin
              pressed <= db;
              state   <= WAIT_RELEASE;
            end
          end else if (timeout_hit) begin
            code  <= 2'b11;
            state <= FAIL;
          end
        end
        WAIT_RELEASE: begin
          if ((db & ~pressed) != 8'd0) begin
            code  <= 2'b10;
            state <= FAIL;
          end else if (db == 8'd0) begin
            idx   <= idx + 5'd1;
            state <= (idx + 5'd1 == len) ? PASS : WAIT_PRESS;
          end
        end
        PASS, FAIL: state <= state;
        default:    state <= IDLE;
      endcase
    end
  end

  always_comb begin
    led         = (state == WAIT_PRESS || state == WAIT_RELEASE) ? db : 8'd0;
    input_count = idx;
    check_end   = (state == PASS) || (state == FAIL);
    check_pass  = (state == PASS);
    check_fail  = (state == FAIL);
    fail_code   = (state == FAIL) ? code : 2'b00;
  end

endmodule

// File: tb/tb_input_pattern_checker.sv
// tb/tb_input_pattern_checker.sv - scoreboard bench for input_pattern_checker with a session-level model
module tb_input_pattern_checker;
  localparam int D = 4;

  logic        clk_1 = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  level = 3'd0;
  logic [47:0] pattern_flat = 48'd0;
  logic [7:0]  btn = 8'd0;
  logic [7:0]  led;
  logic [4:0]  input_count;
  logic        check_end, check_pass, check_fail;
  logic [1:0]  fail_code;

  input_pattern_checker #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(100)) dut (
    .clk_1(clk_1), .rst(rst), .enable(enable), .level(level), .pattern_flat(pattern_flat),
    .btn(btn), .led(led), .input_count(input_count), .check_end(check_end),
    .check_pass(check_pass), .check_fail(check_fail), .fail_code(fail_code)
  );

  always #5 clk_1 = ~clk_1;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];

  int m_pat[16];
  int m_len, m_idx;
  bit m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] ev(int cnt, bit e, bit p, bit f, int code);
    return {5'(cnt), e, p, f, 2'(code)};
  endfunction

  function automatic int idx_of(logic [7:0] m);
    for (int i = 0; i < 8; i++)
      if (m[i]) return i;
    return -1;
  endfunction

  // monitor: an event is a step in input_count or check_end rising
  logic [4:0] prev_cnt = 5'd0;
  logic       prev_end = 1'b0;
  always @(negedge clk_1) begin
    if (rst && ((input_count != prev_cnt && input_count != 5'd0) || (check_end && !prev_end))) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got cnt=%0d end=%b pass=%b fail=%b code=%b expected none",
                 input_count, check_end, check_pass, check_fail, fail_code);
      end else begin
        chk("event", {input_count, check_end, check_pass, check_fail, fail_code}, exp_q.pop_front());
      end
    end
    prev_cnt = input_count;
    prev_end = check_end;
  end

  task automatic start_session(input logic [2:0] lvl, input logic [47:0] p);
    int s;
    level = lvl;
    pattern_flat = p;
    enable = 1'b1;
    for (int k = 0; k < 16; k++) m_pat[k] = int'(p[3*k +: 3]);
    s = 4 + 4 * int'(lvl[0]) + 8 * int'(lvl[1]) + 12 * int'(lvl[2]);
    m_len = (s > 16) ? 16 : s;
    m_idx = 0;
    m_done = 0;
    repeat (3) @(negedge clk_1);
    pattern_flat = 48'({$urandom(), $urandom()});
    level = 3'($urandom_range(0, 7));
  endtask

  task automatic press(input logic [7:0] mask, input int hold);
    bit accepted = 0;
    if (!m_done) begin
      if ($countones(mask) > 1) begin
        exp_q.push_back(ev(m_idx, 1, 0, 1, 2));
        m_done = 1;
      end else if (idx_of(mask) != m_pat[m_idx]) begin
        exp_q.push_back(ev(m_idx, 1, 0, 1, 1));
        m_done = 1;
      end else begin
        accepted = 1;
        m_idx++;
        if (m_idx == m_len) begin
          exp_q.push_back(ev(m_len, 1, 1, 0, 0));
          m_done = 1;
        end else begin
          exp_q.push_back(ev(m_idx, 0, 0, 0, 0));
        end
      end
    end
    btn = mask;
    repeat (hold) @(negedge clk_1);
    chk("led_held", led, accepted ? mask : 8'd0);
    btn = 8'd0;
    repeat (D + 6) @(negedge clk_1);
  endtask

  task automatic end_session();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk_1);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk_1);
    chk("idle_outputs", {led, input_count, check_end, check_pass, check_fail, fail_code}, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] p;
    logic [7:0]  m;
    int          r, a, b;
    int          seq1[8] = '{3, 1, 4, 1, 5, 2, 6, 7};

    repeat (3) @(negedge clk_1);
    chk("reset_outputs", {led, input_count, check_end, check_pass, check_fail, fail_code}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk_1);

    // 1: full correct level-001 sequence
    p = 48'({$urandom(), $urandom()});
    for (int k = 0; k < 8; k++) p[3*k +: 3] = 3'(seq1[k]);
    start_session(3'b001, p);
    for (int k = 0; k < 8; k++) press(8'd1 << seq1[k], D + 4);
    chk("t1_pass", {check_end, check_pass, check_fail, input_count, fail_code}, {3'b110, 5'd8, 2'b00});
    end_session();

    // 2: wrong third button
    start_session(3'b001, p);
    press(8'd1 << 3, D + 5);
    press(8'd1 << 1, D + 5);
    press(8'd1 << 5, D + 5);
    chk("t2_fail", {check_fail, fail_code, input_count}, {1'b1, 2'b01, 5'd2});
    chk("t2_led", led, 0);
    end_session();

    // 3: button held through enable, then two buttons together
    btn = 8'd1 << 1;
    repeat (D + 4) @(negedge clk_1);
    start_session(3'b001, 48'({$urandom(), $urandom()}));
    repeat (20) @(negedge clk_1);
    chk("t3_armed", {check_end, input_count, led}, 0);
    btn = 8'd0;
    repeat (D + 6) @(negedge clk_1);
    press(8'h48, D + 5);
    chk("t3_multi", {check_fail, fail_code, input_count}, {1'b1, 2'b10, 5'd0});
    end_session();

    // 4: glitches on the expected button are filtered
    p = 48'({$urandom(), $urandom()});
    p[2:0] = 3'd2;
    start_session(3'b000, p);
    repeat (3) begin
      btn = 8'h04;
      repeat (2) @(negedge clk_1);
      btn = 8'h00;
      repeat (2) @(negedge clk_1);
    end
    chk("t4_glitch", {input_count, check_end}, 0);
    press(8'h04, 10);
    chk("t4_once", input_count, 1);
    end_session();

    // 5: long wait in WAIT_PRESS
    start_session(3'b001, 48'({$urandom(), $urandom()}));
`ifdef TIMEOUT_EN
    exp_q.push_back(ev(0, 1, 0, 1, 3));
    m_done = 1;
    repeat (200) @(negedge clk_1);
    chk("t5_timeout", {check_fail, fail_code}, 3'b111);
`else
    repeat (200) @(negedge clk_1);
    chk("t5_waiting", check_end, 0);
    press(8'd1 << m_pat[0], D + 4);
    chk("t5_accept", input_count, 1);
`endif
    end_session();

    // 6: async reset mid-session, then enable drop, then fresh session
    start_session(3'b010, 48'({$urandom(), $urandom()}));
    for (int k = 0; k < 3; k++) press(8'd1 << m_pat[m_idx], D + 4);
    chk("t6_count3", input_count, 3);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_reset", {led, input_count, check_end, check_pass, check_fail, fail_code}, 0);
    enable = 1'b0;
    @(negedge clk_1);
    rst = 1'b1;
    @(negedge clk_1);
    start_session(3'b010, 48'({$urandom(), $urandom()}));
    for (int k = 0; k < 3; k++) press(8'd1 << m_pat[m_idx], D + 4);
    enable = 1'b0;
    @(posedge clk_1);
    #1;
    chk("t6_enable_drop", {input_count, check_end}, 0);
    @(negedge clk_1);
    start_session(3'b100, 48'({$urandom(), $urandom()}));
    for (int k = 0; k < 2; k++) press(8'd1 << m_pat[m_idx], D + 4);
    end_session();

    // randomized sessions against the model
    for (int s = 0; s < 8; s++) begin
      r = $urandom_range(0, 3);
      start_session((r == 0) ? 3'b000 : 3'(1 << (r - 1)), 48'({$urandom(), $urandom()}));
      while (!m_done) begin
        r = $urandom_range(0, 11);
        if (r == 0) begin
          a = $urandom_range(0, 7);
          b = (a + $urandom_range(1, 7)) % 8;
          m = (8'd1 << a) | (8'd1 << b);
        end else if (r == 1) begin
          m = 8'd1 << ((m_pat[m_idx] + $urandom_range(1, 7)) % 8);
        end else begin
          m = 8'd1 << m_pat[m_idx];
        end
        press(m, D + 4 + $urandom_range(0, 4));
      end
      end_session();
    end

    chk("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
